// File: rtl/mips_mem_pkg.sv
// Shared types and default sizing for the instruction/data SRAM arbiter.
package mips_mem_pkg;

    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned SRAM_ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF      = 32;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_MEM
    } gnt_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: cleared on load, counts up on inc, done at WAIT_CYCLES.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM controller arbitrating instruction fetch and MEM-stage data.
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN: alternate winners on conflicts.
module sram_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic [DATA_W-1:0]      if_rdata,
    output logic                   if_ready,
    input  logic                   mem_rd_en,
    input  logic                   mem_wr_en,
    input  logic [31:0]            mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    input  logic [DATA_W-1:0]      sram_rdata
);

    state_t state;
    gnt_t   gnt;
    gnt_t   pick;
    logic   wr_flag;
    logic   mem_req;
    logic   start;
    logic   pick_we;
    logic   cnt_done;
    logic   unused_addr_bits;

    assign mem_req = mem_rd_en | mem_wr_en;
    assign freeze  = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // The cycle after a ready pulse is a turnaround: requesters may drop or change.
    assign start   = (state == ST_IDLE) && !if_ready && !mem_ready && (if_req || mem_req);
    assign pick_we = (pick == GNT_MEM) && mem_wr_en;

    assign unused_addr_bits = ^{if_addr[31:SRAM_ADDR_W+2], if_addr[1:0],
                                mem_addr[31:SRAM_ADDR_W+2], mem_addr[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    gnt_t last_srv;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_srv <= GNT_IF;
        end else if (start) begin
            last_srv <= pick;
        end
    end

    always_comb begin
        pick = GNT_IF;
        if (mem_req && if_req) begin
            pick = (last_srv == GNT_IF) ? GNT_MEM : GNT_IF;
        end else if (mem_req) begin
            pick = GNT_MEM;
        end
    end
`else
    // Older instruction (MEM stage) goes first.
    always_comb begin
        pick = GNT_IF;
        if (mem_req) begin
            pick = GNT_MEM;
        end
    end
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .inc  ((state == ST_ACCESS) && !cnt_done),
        .done (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            gnt         <= GNT_IF;
            wr_flag     <= 1'b0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ACCESS;
                        gnt        <= pick;
                        wr_flag    <= pick_we;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= !pick_we;
                        sram_dq_oe <= pick_we;
                        sram_addr  <= (pick == GNT_MEM) ? mem_addr[SRAM_ADDR_W+1:2]
                                                        : if_addr[SRAM_ADDR_W+1:2];
                        if (pick_we) begin
                            sram_dq_out <= mem_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Last bus cycle: sample read data and hand it to the granted port.
                    if (cnt_done) begin
                        state      <= ST_IDLE;
                        sram_ce_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (gnt == GNT_MEM) begin
                            mem_ready <= 1'b1;
                            if (!wr_flag) begin
                                mem_rdata <= sram_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM controller and arbiter shared by the pipeline's instruction-fetch port and MEM-stage data port. Grants one access at a time, sequences the multi-cycle SRAM protocol with a wait-state counter, and returns a one-cycle ready pulse with read data. Drives a pipeline-wide `freeze` while any requester is waiting. Sits between IF_Stage/Mem_Stage and the external SRAM pins.

## Interface
- `WAIT_CYCLES`, 2: SRAM wait states; each access occupies WAIT_CYCLES+1 cycles on the bus.
- `SRAM_ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request, level, held until `if_ready`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out DATA_W: fetched word, valid while `if_ready`=1, held until next fetch completes.
- `if_ready` out 1: one-cycle fetch completion pulse.
- `mem_rd_en` in 1: data read request, level.
- `mem_wr_en` in 1: data write request, level; `mem_rd_en` and `mem_wr_en` are never both 1.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in DATA_W: store data.
- `mem_rdata` out DATA_W: load data, same hold rule as `if_rdata`.
- `mem_ready` out 1: one-cycle data completion pulse (reads and writes).
- `freeze` out 1: pipeline stall.
- `sram_addr` out SRAM_ADDR_W: word address = byte address[SRAM_ADDR_W+1:2].
- `sram_dq_out` out DATA_W: write data; `sram_dq_oe` out 1: drive enable.
- `sram_ce_n` out 1, `sram_we_n` out 1: active-low chip and write enables.
- `sram_rdata` in DATA_W: SRAM read bus.

## Operation
- FSM states: IDLE, ACCESS. Grant register `gnt` ∈ {IF, MEM}; wait counter `cnt`, width clog2(WAIT_CYCLES+1).
- IDLE: if neither ready output is high and a request is pending, latch grant, address, write flag and write data; `cnt`←0; go to ACCESS. While either ready is high, requests are ignored (one turnaround cycle, lets requester drop or change its request).
- Arbitration: fixed priority MEM over IF (older instruction first).
- ACCESS: `sram_ce_n`=0, `sram_addr` from latched address; for writes, `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out`=latched data for all ACCESS cycles. `cnt` increments each cycle.
- On edge with `cnt`==WAIT_CYCLES: capture `sram_rdata` into granted port's rdata (reads only; writes leave `mem_rdata` unchanged), set that port's ready for one cycle, go to IDLE.
- `freeze` = (`if_req` & ~`if_ready`) | ((`mem_rd_en`|`mem_wr_en`) & ~`mem_ready`), combinational.
- Request dropped mid-access: access completes, ready still pulses; requesters must not do this.
- Reset (any state): state IDLE, `cnt`=0, `if_ready`=`mem_ready`=0, `if_rdata`=`mem_rdata`=0, `sram_ce_n`=`sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0; in-flight access abandoned with no ready pulse.

## Timing
- Request visible in IDLE cycle 0 → ACCESS cycles 1..WAIT_CYCLES+1 → ready high in cycle WAIT_CYCLES+2 → earliest next grant decided in cycle WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- All SRAM pins and ready/rdata outputs registered; only `freeze` is combinational.
- Simultaneous IF and MEM requests: MEM served first; IF granted at the first IDLE cycle with no ready high.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, the port not served last wins; the last-served flag resets to IF (so MEM wins the first conflict).
- Not defined: fixed MEM-over-IF priority as above.

## Structure
- Package `mips_mem_pkg`: FSM state enum, grant enum {GNT_IF, GNT_MEM}, default WAIT_CYCLES, SRAM_ADDR_W, DATA_W constants.
- Sub-module `sram_wait_counter`: load/increment counter with `done` = (`cnt`==WAIT_CYCLES).

## Test plan
- Reset: hold `rst`=0 three cycles with requests active → all outputs at reset values, no ready pulse.
- IF read, WAIT_CYCLES=2, `if_addr`=0x10, SRAM word 4 = 0xDEADBEEF → `if_ready` in cycle 4, `if_rdata`=0xDEADBEEF, `freeze`=1 in cycles 0–3.
- MEM write `mem_addr`=0x400, data 0x12345678 → `sram_addr`=0x100, `sram_we_n`=0 for 3 cycles, `mem_ready` cycle 4; a following read of 0x400 returns 0x12345678.
- Simultaneous `if_req` and `mem_rd_en` → MEM ready cycle 4, IF granted cycle 5, IF ready cycle 9.
- With `SRAM_ARB_ROUND_ROBIN_EN`, both ports requesting continuously → grants alternate MEM, IF, MEM, IF.
- `rst`=0 in ACCESS cycle 2 → next cycle IDLE, `sram_ce_n`=1, no ready; re-request after release completes normally.
